// File: rtl/uart_recv_fifo_if.sv
// Host-side bundle of the UART receiver: presented entry, status flags,
// seq/ack toggle handshake and FIFO level/flow control.
interface uart_recv_fifo_if #(
  parameter int DATABITS = 8,
  parameter int DEPTH    = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATABITS-1:0] data;
  logic                parity_err;
  logic                frame_err;
  logic                brk;
  logic                overrun;
  logic                seq;
  logic                ack;
  logic [LVL_W-1:0]    level;
  logic                cts;

  modport master (
    output data, parity_err, frame_err, brk, overrun, seq, level, cts,
    input  ack
  );

  modport slave (
    input  data, parity_err, frame_err, brk, overrun, seq, level, cts,
    output ack
  );
endinterface

// File: rtl/uart_recv_fifo.sv
// UART receiver with majority-voted sampling, per-frame status and a receive
// FIFO drained through a seq/ack toggle handshake.
module uart_recv_fifo #(
  parameter int DATABITS = 8,
  parameter int BAUDDIV  = 12,
  parameter int PARITY   = 0,
  parameter int STOPBITS = 1,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             rx,
  uart_recv_fifo_if.master bus
);

  localparam int M     = BAUDDIV / 2;
  localparam int SC_W  = $clog2(BAUDDIV);
  localparam int BC_W  = $clog2(DATABITS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATABITS + 3;

  localparam logic [SC_W-1:0] SC_A    = SC_W'(M - 1);
  localparam logic [SC_W-1:0] SC_B    = SC_W'(M);
  localparam logic [SC_W-1:0] SC_C    = SC_W'(M + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(BAUDDIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATABITS - 1);

  localparam logic [2:0] WAIT_IDL = 3'd0;
  localparam logic [2:0] IDLE     = 3'd1;
  localparam logic [2:0] START    = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] PAR      = 3'd4;
  localparam logic [2:0] STOP     = 3'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_bad(input logic [DATABITS-1:0] d, input logic p);
    return (^d ^ p) != (PARITY == 2);
  endfunction

  logic                rx_p0;
  logic                rs;
  logic [2:0]          state;
  logic [SC_W-1:0]     sub_count;
  logic [1:0]          smp;
  logic [BC_W-1:0]     bit_cnt;
  logic                stop_cnt;
  logic [DATABITS-1:0] sh;
  logic                pbit;
  logic                ferr;
  logic                stop0;

  logic                push_vld;
  logic [DATABITS-1:0] push_data;
  logic                push_perr;
  logic                push_ferr;
  logic                push_brk;

  logic                maj;
  logic                decide;
  logic                bit_end;
  logic                last_stop;
  logic                first_stop;
  logic                frame_brk;
  logic                push_now;

  // Stage 0: two-flop synchroniser, idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rs    <= rx_p0;
    end
  end

  always_comb begin
    maj        = maj3(smp[0], smp[1], rs);
    decide     = (sub_count == SC_C);
    bit_end    = (sub_count == SC_LAST);
    last_stop  = (STOPBITS == 1) || stop_cnt;
    first_stop = stop_cnt ? stop0 : maj;
    frame_brk  = (sh == '0) && ((PARITY == 0) || !pbit) && !first_stop;
    push_now   = (state == STOP) && decide && last_stop;
  end

  // Stage 1: bit-timing FSM
  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      state     <= WAIT_IDL;
      sub_count <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      sub_count <= bit_end ? '0 : sub_count + SC_W'(1);
      if (sub_count == SC_A) smp[0] <= rs;
      if (sub_count == SC_B) smp[1] <= rs;
      case (state)
        WAIT_IDL: begin
          sub_count <= '0;
          if (rs) state <= IDLE;
        end
        IDLE: begin
          sub_count <= '0;
          if (!rs) state <= START;
        end
        START: begin
          if (decide && maj) begin
            state <= IDLE;
          end else if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (decide) sh <= {maj, sh[DATABITS-1:1]};
          if (bit_end) begin
            if (bit_cnt == BC_LAST) begin
              state    <= (PARITY != 0) ? PAR : STOP;
              stop_cnt <= 1'b0;
              ferr     <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        end
        PAR: begin
          if (decide) pbit <= maj;
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        STOP: begin
          // A break leaves the line low, so wait for idle before re-arming
          if (push_now) begin
            state <= frame_brk ? WAIT_IDL : IDLE;
          end else begin
            if (decide) begin
              ferr  <= ferr | ~maj;
              stop0 <= maj;
            end
            if (bit_end) stop_cnt <= 1'b1;
          end
        end
        default: state <= WAIT_IDL;
      endcase
    end
  end

  // Stage 2: completed frame waits one cycle before entering the FIFO
  always_ff @(posedge clk) begin
    if (reset) push_vld <= 1'b0;
    else       push_vld <= push_now && !soft_reset;
  end

  always_ff @(posedge clk) begin
    if (push_now) begin
      push_data <= sh;
      push_perr <= (PARITY != 0) ? par_bad(sh, pbit) : 1'b0;
      push_ferr <= ferr | ~maj;
      push_brk  <= frame_brk;
    end
  end

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    cnt;
  logic [LVL_W-1:0]    cnt_next;
  logic                presented;
  logic                seq_r;
  logic                overrun_r;
  logic                cts_r;
  logic [DATABITS-1:0] data_r;
  logic                perr_r;
  logic                ferr_r;
  logic                brk_r;
  logic                full;
  logic                do_push;
  logic                do_pop;
  logic                drop;
  logic                load;

  always_comb begin
    full     = (cnt == LVL_W'(DEPTH));
    do_push  = push_vld && !full;
    drop     = push_vld && full;
    do_pop   = presented && (bus.ack == seq_r);
    load     = !presented && (cnt != '0);
    cnt_next = cnt + LVL_W'(do_push) - LVL_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_data, push_perr, push_ferr, push_brk};
  end

  // Stage 3: FIFO bookkeeping and presentation of the head entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      presented <= 1'b0;
      seq_r     <= 1'b0;
      overrun_r <= 1'b0;
      cts_r     <= 1'b0;
      data_r    <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      brk_r     <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      cts_r <= (cnt_next >= LVL_W'(DEPTH - 1));
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (drop)        overrun_r <= 1'b1;
      else if (do_pop) overrun_r <= 1'b0;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        presented <= 1'b0;
      end
      if (load) begin
        {data_r, perr_r, ferr_r, brk_r} <= mem[rd_ptr];
        presented <= 1'b1;
        seq_r     <= ~seq_r;
      end
    end
  end

  assign bus.data       = data_r;
  assign bus.parity_err = perr_r;
  assign bus.frame_err  = ferr_r;
  assign bus.brk        = brk_r;
  assign bus.overrun    = overrun_r;
  assign bus.seq        = seq_r;
  assign bus.level      = cnt;
  assign bus.cts        = cts_r;

endmodule

// File: tb/tb_uart_recv_fifo.sv
// Directed bench for uart_recv_fifo: table of single frames plus hand-written
// break, glitch, overrun, soft_reset and reset sequences.
module tb_uart_recv_fifo;
  localparam int BD = 12;
  localparam int FRAME = 11 * BD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic soft_reset = 1'b0;
  logic rx = 1'b1;
  logic exp_seq = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  uart_recv_fifo_if #(.DATABITS(8), .DEPTH(4)) bus ();
  uart_recv_fifo_if #(.DATABITS(8), .DEPTH(4)) bus2 ();

  uart_recv_fifo #(.DATABITS(8), .BAUDDIV(BD), .PARITY(1), .STOPBITS(1), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .rx(rx), .bus(bus));

  uart_recv_fifo #(.DATABITS(8), .BAUDDIV(BD), .PARITY(2), .STOPBITS(1), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .rx(rx), .bus(bus2));

  // The odd-parity instance is drained as soon as each entry appears
  assign bus2.ack = bus2.seq;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic       gl;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    logic       e_brk;
    logic       e_perr2;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic pb, input logic sb, input logic gl,
                      input int ncyc, input int gap);
    logic [10:0] bits;
    logic v;
    bits = {sb, pb, d, 1'b0};
    for (int c = 0; c < ncyc && c < FRAME; c++) begin
      v = bits[c / BD];
      if (gl && v && (c % BD) == 7) v = 1'b0;
      @(posedge clk); #1 rx = v;
    end
    @(posedge clk); #1 rx = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_seq(input string name);
    int n;
    n = 0;
    while (bus.seq !== exp_seq && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, bus.seq, exp_seq);
  endtask

  task automatic pop();
    @(posedge clk); #1 bus.ack = exp_seq;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{8'h12, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0};

    bus.ack = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_level", bus.level, 0);
    chk("rst_seq", bus.seq, 0);
    chk("rst_cts", bus.cts, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_flags", {bus.parity_err, bus.frame_err, bus.brk}, 0);

    for (int i = 0; i < 6; i++) begin
      exp_seq ^= 1'b1;
      send(vt[i].d, vt[i].pb, vt[i].sb, vt[i].gl, FRAME, 20);
      wait_seq($sformatf("v%0d_seq", i));
      chk($sformatf("v%0d_data", i), bus.data, vt[i].e_data);
      chk($sformatf("v%0d_perr", i), bus.parity_err, vt[i].e_perr);
      chk($sformatf("v%0d_ferr", i), bus.frame_err, vt[i].e_ferr);
      chk($sformatf("v%0d_brk", i), bus.brk, vt[i].e_brk);
      chk($sformatf("v%0d_level", i), bus.level, 1);
      chk($sformatf("v%0d_odd_data", i), bus2.data, vt[i].e_data);
      chk($sformatf("v%0d_odd_perr", i), bus2.parity_err, vt[i].e_perr2);
      pop();
      chk($sformatf("v%0d_level_pop", i), bus.level, 0);
    end

    // Three-cycle low pulse is a rejected start bit
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("glitch_seq", bus.seq, exp_seq);
    chk("glitch_level", bus.level, 0);

    // Break: line low for two frame times yields one entry
    exp_seq ^= 1'b1;
    @(posedge clk); #1 rx = 1'b0;
    repeat (2 * FRAME) @(posedge clk);
    wait_seq("brk_seq");
    chk("brk_data", bus.data, 0);
    chk("brk_flag", bus.brk, 1);
    chk("brk_ferr", bus.frame_err, 1);
    chk("brk_perr", bus.parity_err, 0);
    repeat (150) @(posedge clk);
    @(negedge clk);
    chk("brk_single_level", bus.level, 1);
    chk("brk_single_seq", bus.seq, exp_seq);
    pop();
    @(posedge clk); #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("brk_idle_level", bus.level, 0);
    chk("brk_idle_seq", bus.seq, exp_seq);
    exp_seq ^= 1'b1;
    send(8'h12, 1'b0, 1'b1, 1'b0, FRAME, 20);
    wait_seq("post_brk_seq");
    chk("post_brk_data", bus.data, 8'h12);
    chk("post_brk_flags", {bus.parity_err, bus.frame_err, bus.brk}, 0);
    pop();

    // Overrun: six frames into a four-entry FIFO with no acknowledge
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) exp_seq ^= 1'b1;
      send(8'(k), ^(8'(k)), 1'b1, 1'b0, FRAME, 20);
      @(negedge clk);
      if (k == 2) begin
        chk("ovr_lvl2", bus.level, 2);
        chk("ovr_cts2", bus.cts, 0);
      end
      if (k == 3) begin
        chk("ovr_lvl3", bus.level, 3);
        chk("ovr_cts3", bus.cts, 1);
      end
    end
    chk("ovr_level", bus.level, 4);
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_cts", bus.cts, 1);
    for (int i = 1; i <= 4; i++) begin
      wait_seq($sformatf("drain%0d_seq", i));
      chk($sformatf("drain%0d_data", i), bus.data, i);
      pop();
      if (i == 1) chk("ovr_clear", bus.overrun, 0);
      if (i < 4) exp_seq ^= 1'b1;
    end
    chk("drain_level", bus.level, 0);
    chk("drain_cts", bus.cts, 0);

    // soft_reset during bit 4 discards the frame and keeps the FIFO
    exp_seq ^= 1'b1;
    send(8'h11, 1'b0, 1'b1, 1'b0, FRAME, 20);
    send(8'h22, 1'b0, 1'b1, 1'b0, FRAME, 20);
    send(8'h00, 1'b0, 1'b1, 1'b0, 5 * BD + 4, 0);
    @(posedge clk); #1 soft_reset = 1'b1;
    @(posedge clk); #1 soft_reset = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("srst_level", bus.level, 2);
    chk("srst_seq", bus.seq, exp_seq);
    chk("srst_data", bus.data, 8'h11);

    // Full reset mid-frame flushes everything
    send(8'h00, 1'b0, 1'b1, 1'b0, 5 * BD + 4, 0);
    @(posedge clk); #1 reset = 1'b1; bus.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    exp_seq = 1'b0;
    chk("hrst_level", bus.level, 0);
    chk("hrst_seq", bus.seq, 0);
    chk("hrst_cts", bus.cts, 0);
    chk("hrst_data", bus.data, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("hrst_quiet_level", bus.level, 0);
    exp_seq = 1'b1;
    send(8'hC3, 1'b0, 1'b1, 1'b0, FRAME, 20);
    wait_seq("hrst_c3_seq");
    chk("hrst_c3_data", bus.data, 8'hC3);
    chk("hrst_c3_flags", {bus.parity_err, bus.frame_err, bus.brk}, 0);
    chk("hrst_c3_level", bus.level, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
